am_env_detect: RTL and testbench
================================

AM_ENV_DETECT -- requirements
Module: am_env_detect

Interface
REQ-001 Parameter WIN_LEN, default 120: valid samples per envelope window (legal range 2..4095).
REQ-002 Parameter FRAME_LEN, default 64: envelope samples per depth frame (legal range 2..255).
REQ-003 clk  in  1  single clock for all logic.
REQ-004 rst_n  in  1  reset; synchronous and active-low.
REQ-005 en  in  1  run enable; low = idle.
REQ-006 adc_valid  in  1  adc_data qualifier.
REQ-007 adc_data  in  12  sample in offset binary; midscale = 2048.
REQ-008 env_valid  out  1  one-cycle pulse marking a new env_data.
REQ-009 env_data  out  12  window peak of the rectified sample.
REQ-010 frame_valid  out  1  one-cycle pulse marking new frame outputs.
REQ-011 frame_max  out  12  largest env_data in the frame.
REQ-012 frame_min  out  12  smallest env_data in the frame.
REQ-013 depth_num  out  13  frame_max - frame_min, zero-extended.
REQ-014 depth_den  out  13  frame_max + frame_min.

Function
REQ-015 States: IDLE and RUN. IDLE->RUN on a cycle with en=1. RUN->IDLE on a cycle with en=0.
REQ-016 Entering IDLE SHALL clear the window count, frame count and peak register, and set the frame min tracker to 4095 and the frame max tracker to 0. The partial window and partial frame are discarded.
REQ-017 Registered outputs hold their last values in IDLE.
REQ-018 In RUN, a sample is accepted only when adc_valid=1. Samples with adc_valid=0 change no state.
REQ-019 Rectification: r = adc_data-2048 if adc_data>=2048, else 2048-adc_data. The range is 0..2048, so 12 bits with no overflow.
REQ-020 Peak register: on each accepted sample, peak <= max(peak, r).
REQ-021 Window counter counts accepted samples 0..WIN_LEN-1 and wraps to 0.
REQ-022 On the accepted sample at count WIN_LEN-1:
- env_data <= max(peak, r)
- env_valid = 1 on the next cycle only
- peak <= 0 in the same cycle
REQ-023 Latency: the last window sample accepted in cycle N produces env_valid in cycle N+1.
REQ-024 Each env_valid updates the frame trackers: fmax <= max(fmax, env), fmin <= min(fmin, env). The frame counter counts 0..FRAME_LEN-1 and wraps.
REQ-025 When the env_valid completes a frame:
- frame_max, frame_min, depth_num and depth_den are loaded from the final tracker values, including that last envelope
- frame_valid = 1 one cycle after that env_valid (cycle N+2)
- trackers reset to fmax=0, fmin=4095 in the same cycle
REQ-026 env_valid and frame_valid are never asserted for more than one consecutive cycle per event. They are never asserted in IDLE, except for a pulse already scheduled by the cycle before en fell.
REQ-027 If en falls in the same cycle as a window-completing sample, that sample is dropped (en=0 has priority). No env_valid is produced for it.
REQ-028 Back-to-back accepted samples every cycle are supported at full rate with no stalls.

Reset
REQ-029 While rst_n=0 at a clk edge: state=IDLE; all counters and peak = 0; trackers fmax=0, fmin=4095; all outputs = 0.
REQ-030 Reset asserted mid-window or mid-frame discards all partial results. After release, the first window begins with the first accepted sample.

Verification (WIN_LEN=4, FRAME_LEN=2)
REQ-031 Window peak: en=1; samples 2048, 2100, 1900, 2060 -> one env_valid one cycle after the 4th sample, with env_data=148.
REQ-032 Full-scale corners: samples 0, 4095, 2048, 2048 -> env_data=2048. Then the next window 2049, 2047, 2048, 2050 -> env_data=2.
REQ-033 Frame: the two windows of REQ-032 -> frame_valid at N+2 with frame_max=2048, frame_min=2, depth_num=2046, depth_den=2050.
REQ-034 Gapped valid: adc_valid toggling 1,0,1,0 across the REQ-031 samples -> same env_data=148. No pulse before the 4th accepted sample.
REQ-035 Abort: en drops after 3 accepted samples, then returns. Four new samples of 2148 follow -> env_data=100. The earlier samples do not contribute.
REQ-036 Reset mid-frame: rst_n low for 1 cycle after one envelope of 500 -> all outputs 0. The next frame's min/max exclude the value 500.

Source files
------------

// File: rtl/am_env_detect.sv
// AM envelope detector: rectifies offset-binary samples, takes the peak over each window, and
// reports the per-frame envelope max/min along with the modulation-depth numerator and denominator.
module am_env_detect #(
    parameter int unsigned WIN_LEN   = 120,
    parameter int unsigned FRAME_LEN = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        adc_valid,
    input  logic [11:0] adc_data,
    output logic        env_valid,
    output logic [11:0] env_data,
    output logic        frame_valid,
    output logic [11:0] frame_max,
    output logic [11:0] frame_min,
    output logic [12:0] depth_num,
    output logic [12:0] depth_den
);

    localparam logic StIdle = 1'b0;
    localparam logic StRun  = 1'b1;

    localparam logic [11:0] WinLast   = 12'(WIN_LEN - 1);
    localparam logic [7:0]  FrameLast = 8'(FRAME_LEN - 1);

    logic        state_q;
    logic [11:0] win_cnt_q;
    logic [11:0] peak_q;
    logic [7:0]  frame_cnt_q;
    logic [11:0] fmax_q;
    logic [11:0] fmin_q;
    logic        env_valid_q;
    logic [11:0] env_data_q;
    logic        frame_valid_q;
    logic [11:0] frame_max_q;
    logic [11:0] frame_min_q;
    logic [12:0] depth_num_q;
    logic [12:0] depth_den_q;

    logic [11:0] rect;
    logic [11:0] peak_max;
    logic [11:0] trk_max;
    logic [11:0] trk_min;
    logic        run;
    logic        accept;
    logic        win_done;
    logic        trk_upd;
    logic        frame_done;

    always_comb begin
        // Below midscale the subtraction tops out at 2048, which still fits in 12 bits.
        rect       = adc_data[11] ? {1'b0, adc_data[10:0]} : (12'd2048 - adc_data);
        peak_max   = (rect > peak_q) ? rect : peak_q;
        trk_max    = (env_data_q > fmax_q) ? env_data_q : fmax_q;
        trk_min    = (env_data_q < fmin_q) ? env_data_q : fmin_q;
        run        = (state_q == StRun) && en;
        accept     = run && adc_valid;
        win_done   = accept && (win_cnt_q == WinLast);
        trk_upd    = run && env_valid_q;
        frame_done = trk_upd && (frame_cnt_q == FrameLast);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            win_cnt_q     <= '0;
            peak_q        <= '0;
            frame_cnt_q   <= '0;
            fmax_q        <= '0;
            fmin_q        <= 12'd4095;
            env_valid_q   <= 1'b0;
            env_data_q    <= '0;
            frame_valid_q <= 1'b0;
            frame_max_q   <= '0;
            frame_min_q   <= '0;
            depth_num_q   <= '0;
            depth_den_q   <= '0;
        end else begin
            env_valid_q   <= win_done;
            frame_valid_q <= frame_done;
            if (state_q == StIdle) begin
                if (en) begin
                    state_q <= StRun;
                end
            end else if (!en) begin
                // Leaving RUN drops any partial window/frame, including a sample in this cycle.
                state_q     <= StIdle;
                win_cnt_q   <= '0;
                peak_q      <= '0;
                frame_cnt_q <= '0;
                fmax_q      <= '0;
                fmin_q      <= 12'd4095;
            end else begin
                if (accept) begin
                    if (win_done) begin
                        win_cnt_q  <= '0;
                        peak_q     <= '0;
                        env_data_q <= peak_max;
                    end else begin
                        win_cnt_q <= win_cnt_q + 12'd1;
                        peak_q    <= peak_max;
                    end
                end
                if (trk_upd) begin
                    if (frame_done) begin
                        frame_cnt_q <= '0;
                        fmax_q      <= '0;
                        fmin_q      <= 12'd4095;
                        frame_max_q <= trk_max;
                        frame_min_q <= trk_min;
                        depth_num_q <= {1'b0, trk_max - trk_min};
                        depth_den_q <= {1'b0, trk_max} + {1'b0, trk_min};
                    end else begin
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                        fmax_q      <= trk_max;
                        fmin_q      <= trk_min;
                    end
                end
            end
        end
    end

    assign env_valid   = env_valid_q;
    assign env_data    = env_data_q;
    assign frame_valid = frame_valid_q;
    assign frame_max   = frame_max_q;
    assign frame_min   = frame_min_q;
    assign depth_num   = depth_num_q;
    assign depth_den   = depth_den_q;

endmodule

// File: tb/tb_am_env_detect.sv
// Directed-vector bench for am_env_detect with WIN_LEN=4, FRAME_LEN=2.
module tb_am_env_detect;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        adc_valid;
    logic [11:0] adc_data;
    logic        env_valid;
    logic [11:0] env_data;
    logic        frame_valid;
    logic [11:0] frame_max;
    logic [11:0] frame_min;
    logic [12:0] depth_num;
    logic [12:0] depth_den;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    am_env_detect #(
        .WIN_LEN  (4),
        .FRAME_LEN(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .adc_valid  (adc_valid),
        .adc_data   (adc_data),
        .env_valid  (env_valid),
        .env_data   (env_data),
        .frame_valid(frame_valid),
        .frame_max  (frame_max),
        .frame_min  (frame_min),
        .depth_num  (depth_num),
        .depth_den  (depth_den)
    );

    typedef struct {
        logic        en;
        logic        v;
        logic [11:0] data;
        logic        ev;
        logic [11:0] env;
        logic        fv;
        logic [11:0] fmax;
        logic [11:0] fmin;
        logic [12:0] dnum;
        logic [12:0] dden;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic e, input logic v, input int d, input logic ev, input int env,
                       input logic fv, input int fmx, input int fmn, input int dn, input int dd);
        vec_t t;
        t.en = e; t.v = v; t.data = 12'(d); t.ev = ev; t.env = 12'(env); t.fv = fv;
        t.fmax = 12'(fmx); t.fmin = 12'(fmn); t.dnum = 13'(dn); t.dden = 13'(dd);
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic ev, input int env, input logic fv,
                             input int fmx, input int fmn, input int dn, input int dd);
        check("env_valid", idx, int'(env_valid), int'(ev));
        check("env_data", idx, int'(env_data), env);
        check("frame_valid", idx, int'(frame_valid), int'(fv));
        check("frame_max", idx, int'(frame_max), fmx);
        check("frame_min", idx, int'(frame_min), fmn);
        check("depth_num", idx, int'(depth_num), dn);
        check("depth_den", idx, int'(depth_den), dd);
    endtask

    // Drive inputs, advance one clock, leave the bench 1 time unit past the edge.
    task automatic step(input logic e, input logic v, input int d);
        en = e; adc_valid = v; adc_data = 12'(d);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; adc_valid = 1'b0; adc_data = '0;

        // Window peak: rectified 0, 52, 148, 12
        add(1, 0, 0,    0, 0,    0, 0, 0, 0, 0);
        add(1, 1, 2048, 0, 0,    0, 0, 0, 0, 0);
        add(1, 1, 2100, 0, 0,    0, 0, 0, 0, 0);
        add(1, 1, 1900, 0, 0,    0, 0, 0, 0, 0);
        add(1, 1, 2060, 1, 148,  0, 0, 0, 0, 0);
        // Brief idle so the next two windows form one frame
        add(0, 0, 0,    0, 148,  0, 0, 0, 0, 0);
        add(1, 0, 0,    0, 148,  0, 0, 0, 0, 0);
        // Full-scale corners
        add(1, 1, 0,    0, 148,  0, 0, 0, 0, 0);
        add(1, 1, 4095, 0, 148,  0, 0, 0, 0, 0);
        add(1, 1, 2048, 0, 148,  0, 0, 0, 0, 0);
        add(1, 1, 2048, 1, 2048, 0, 0, 0, 0, 0);
        add(1, 1, 2049, 0, 2048, 0, 0, 0, 0, 0);
        add(1, 1, 2047, 0, 2048, 0, 0, 0, 0, 0);
        add(1, 1, 2048, 0, 2048, 0, 0, 0, 0, 0);
        add(1, 1, 2050, 1, 2,    0, 0, 0, 0, 0);
        add(1, 0, 0,    0, 2,    1, 2048, 2, 2046, 2050);
        add(1, 0, 0,    0, 2,    0, 2048, 2, 2046, 2050);
        // Gapped valid; invalid cycles carry large junk that must be ignored
        add(1, 1, 2048, 0, 2,    0, 2048, 2, 2046, 2050);
        add(1, 0, 4095, 0, 2,    0, 2048, 2, 2046, 2050);
        add(1, 1, 2100, 0, 2,    0, 2048, 2, 2046, 2050);
        add(1, 0, 4095, 0, 2,    0, 2048, 2, 2046, 2050);
        add(1, 1, 1900, 0, 2,    0, 2048, 2, 2046, 2050);
        add(1, 0, 4095, 0, 2,    0, 2048, 2, 2046, 2050);
        add(1, 1, 2060, 1, 148,  0, 2048, 2, 2046, 2050);
        add(1, 0, 0,    0, 148,  0, 2048, 2, 2046, 2050);
        // Abort: three accepted, the window-completing fourth arrives with en=0
        add(1, 1, 4095, 0, 148,  0, 2048, 2, 2046, 2050);
        add(1, 1, 4095, 0, 148,  0, 2048, 2, 2046, 2050);
        add(1, 1, 4095, 0, 148,  0, 2048, 2, 2046, 2050);
        add(0, 1, 4095, 0, 148,  0, 2048, 2, 2046, 2050);
        add(1, 0, 0,    0, 148,  0, 2048, 2, 2046, 2050);
        add(1, 1, 2148, 0, 148,  0, 2048, 2, 2046, 2050);
        add(1, 1, 2148, 0, 148,  0, 2048, 2, 2046, 2050);
        add(1, 1, 2148, 0, 148,  0, 2048, 2, 2046, 2050);
        add(1, 1, 2148, 1, 100,  0, 2048, 2, 2046, 2050);
        // Frame tracker was cleared by the abort, so 100 starts a fresh frame
        add(1, 0, 0,    0, 100,  0, 2048, 2, 2046, 2050);
        add(1, 1, 2048, 0, 100,  0, 2048, 2, 2046, 2050);
        add(1, 1, 2048, 0, 100,  0, 2048, 2, 2046, 2050);
        add(1, 1, 2048, 0, 100,  0, 2048, 2, 2046, 2050);
        add(1, 1, 2348, 1, 300,  0, 2048, 2, 2046, 2050);
        add(1, 0, 0,    0, 300,  1, 300, 100, 200, 400);
        add(1, 0, 0,    0, 300,  0, 300, 100, 200, 400);

        // Reset state
        step(1, 1, 4095);
        step(1, 1, 4095);
        check_all(-1, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].en, vecs[i].v, int'(vecs[i].data));
            check_all(i, vecs[i].ev, int'(vecs[i].env), vecs[i].fv, int'(vecs[i].fmax),
                      int'(vecs[i].fmin), int'(vecs[i].dnum), int'(vecs[i].dden));
        end

        // Reset mid-frame after one envelope of 500
        for (int i = 0; i < 4; i++) step(1, 1, 2548);
        check("env500", 100, int'(env_data), 500);
        check("env500_valid", 100, int'(env_valid), 1);
        step(1, 0, 0);
        rst_n = 1'b0;
        step(1, 1, 2548);
        check_all(101, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step(1, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 2048);
        step(1, 1, 2148);
        check("post_rst_env", 102, int'(env_data), 100);
        step(1, 0, 0);
        check("post_rst_no_frame", 103, int'(frame_valid), 0);
        for (int i = 0; i < 3; i++) step(1, 1, 2048);
        step(1, 1, 2348);
        step(1, 0, 0);
        check_all(104, 0, 300, 1, 300, 100, 200, 400);
        step(1, 0, 0);
        check("frame_pulse_end", 105, int'(frame_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
